pwm_multi: RTL and testbench
============================

// Module: pwm_multi
// PURPOSE
//  NCH-channel PWM generator sharing one prescaler and one period counter.
//  Supports edge-aligned and center-aligned modes, per-channel duty and polarity.
//  Period, duty and mode are double-buffered and commit only at a period boundary.
//  Drives LED/motor/heater outputs from the control register bank.
// PARAMETERS
//  NCH   4   number of PWM channels
//  CW    16  period counter / duty width (bits)
//  PSW   8   prescaler width (bits)
// PORTS
//  sclk        in   1       system clock
//  rstn        in   1       async reset, active low
//  en          in   1       run enable; 0 = counters held, outputs inactive
//  prescale    in   PSW     counter advances every prescale+1 sclk cycles
//  period      in   CW      period value P
//  duty        in   NCH*CW  channel i duty = duty[i*CW +: CW]
//  center      in   1       0 = edge-aligned, 1 = center-aligned
//  polarity    in   NCH     1 = invert channel output
//  load        in   1       1-cycle strobe: capture period/duty/center into shadow
//  pending     out  1       shadow holds values not yet committed
//  period_tick out  1       1-cycle pulse on each period boundary
//  pwm_out     out  NCH     registered PWM outputs
// BEHAVIOUR
//  Reset (rstn=0, async)
//   - Prescaler, counter and direction clear.
//   - Active and shadow period/duty/center clear.
//   - pending=0, period_tick=0, pwm_out=0.
//  Prescaler
//   - pcnt counts 0..prescale; tick=1 on the cycle pcnt==prescale, then pcnt wraps to 0.
//   - prescale=0 gives tick every cycle.
//  Edge mode
//   - Counter sequence 0..P, then wraps to 0.
//   - Period length P+1 ticks; boundary is the tick at cnt==P.
//  Center mode
//   - Counter sequence 0,1..P,P-1..1, then repeats.
//   - Period length 2P ticks; boundary is the last tick of the sequence.
//   - P=0: counter held at 0, boundary on every tick.
//  Compare
//   - raw[i] = (cnt < duty_act[i]).
//   - duty=0 gives always low; duty>P (edge) or duty>P (center) gives always high.
//   - pwm_out[i] <= raw[i] ^ polarity[i]; one sclk of latency from cnt.
//   - polarity is not shadowed and takes effect immediately.
//  Shadow / commit
//   - load: shadow <= {period, duty, center}; pending <= 1.
//   - On boundary with pending=1: active <= shadow; pending <= 0; counter restarts at 0, direction up.
//   - On boundary with pending=0: active values unchanged.
//   - load and boundary in the same cycle: old shadow commits; new values enter shadow; pending stays 1.
//   - A second load before commit overwrites the shadow (last write wins).
//  period_tick
//   - Registered 1-cycle pulse, the cycle after each boundary, while en=1.
//  Disable (en=0)
//   - pcnt=0, cnt=0, direction up, period_tick=0.
//   - pwm_out = polarity (inactive level).
//   - A pending shadow commits on the next cycle; pending then clears.
//   - On en rising: counting starts at cnt=0; the first pwm_out reflects cnt=0 one cycle later.
//  Mid-period changes to the period/duty inputs without load have no effect.
//  Widths: all compares are unsigned CW-bit; counters never exceed P.
// STRUCTURE
//  pwm_pkg
//   - localparams MODE_EDGE=1'b0, MODE_CENTER=1'b1.
//   - Default CW/PSW values.
//  Sub-module pwm_ch_cmp (one per channel, generate loop)
//   - Inputs: cnt, duty_act, polarity, en.
//   - Output: registered pwm_out bit.
//  Top level
//   - Prescaler, counter/direction FSM (UP, DOWN), shadow regs, commit logic.
// TESTING
//  1. Edge mode
//     - Stimulus: presc=0, P=9, duty0=3, load, en=1.
//     - Response: out0 high 3 of every 10 cycles; period_tick every 10 cycles.
//  2. Center mode
//     - Stimulus: P=4, duty=2, presc=0.
//     - Response: cnt 0,1,2,3,4,3,2,1; out high at cnt 0,1,1 (3 of 8); tick every 8 cycles.
//  3. Shadow commit
//     - Stimulus: duty 3->7 loaded mid-period (P=9).
//     - Response: current period keeps 3 high; next period 7 high; pending 1 until boundary.
//  4. Coincident load
//     - Stimulus: load on the boundary cycle.
//     - Response: previous shadow commits; pending stays 1; new value commits at the following boundary.
//  5. Extremes
//     - Stimulus 1: duty=0.
//     - Response 1: always low.
//     - Stimulus 2: duty=P+1 with P=9.
//     - Response 2: always high.
//     - Stimulus 3: polarity=1.
//     - Response 3: output inverted.
//     - Stimulus 4: presc=2.
//     - Response 4: all timings x3.
//  6. Reset/disable
//     - Stimulus: rstn low mid-period.
//     - Response: pwm_out=0 immediately.
//     - Stimulus: en=0.
//     - Response: pwm_out=polarity next cycle, cnt=0; restart from cnt=0 on re-enable.

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and types for the multi-channel PWM
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    localparam int DEF_NCH = 4;
    localparam int DEF_CW  = 16;
    localparam int DEF_PSW = 8;

    typedef enum logic {
        S_UP   = 1'b0,
        S_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/pwm_ch_cmp.sv
// rtl/pwm_ch_cmp.sv - per-channel duty compare with registered, polarity-adjusted output
module pwm_ch_cmp
    import pwm_pkg::*;
#(
    parameter int CW = DEF_CW
) (
    input  logic          sclk,
    input  logic          rstn,
    input  logic          en,
    input  logic [CW-1:0] cnt,
    input  logic [CW-1:0] duty_act,
    input  logic          polarity,
    output logic          pwm_out
);

    // Output is active while the counter is below duty; idles at the polarity level when disabled
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            pwm_out <= 1'b0;
        end else if (!en) begin
            pwm_out <= polarity;
        end else begin
            pwm_out <= (cnt < duty_act) ^ polarity;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - NCH-channel PWM with shared prescaler/counter and double-buffered settings
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int CW  = DEF_CW,
    parameter int PSW = DEF_PSW
) (
    input  logic              sclk,
    input  logic              rstn,
    input  logic              en,
    input  logic [PSW-1:0]    prescale,
    input  logic [CW-1:0]     period,
    input  logic [NCH*CW-1:0] duty,
    input  logic              center,
    input  logic [NCH-1:0]    polarity,
    input  logic              load,
    output logic              pending,
    output logic              period_tick,
    output logic [NCH-1:0]    pwm_out
);

    logic [PSW-1:0]    pcnt;
    logic              tick;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    dir_t              state;
    dir_t              state_nxt;
    logic              bnd;
    logic              commit;

    logic [CW-1:0]     p_act;
    logic [CW-1:0]     p_sh;
    logic [NCH*CW-1:0] duty_act;
    logic [NCH*CW-1:0] duty_sh;
    logic              c_act;
    logic              c_sh;

    // >= keeps the prescaler from running away if prescale is lowered below pcnt
    assign tick = en && (pcnt >= prescale);

    // Prescaler: count 0..prescale, held cleared while disabled
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            pcnt <= '0;
        end else if (!en || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PSW'(1);
        end
    end

    // Counter/direction next state; boundary is the last tick of a period in either mode
    always_comb begin
        cnt_nxt   = cnt;
        state_nxt = state;
        bnd       = 1'b0;
        if (tick) begin
            if (c_act == MODE_EDGE) begin
                if (cnt >= p_act) begin
                    bnd = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end else if (state == S_UP) begin
                if (cnt >= p_act) begin
                    // P of 0 or 1 has no down leg: the peak is also the period end
                    if (p_act <= CW'(1)) begin
                        bnd = 1'b1;
                    end else begin
                        cnt_nxt   = p_act - CW'(1);
                        state_nxt = S_DOWN;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end else begin
                if (cnt <= CW'(1)) begin
                    bnd = 1'b1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            if (bnd) begin
                cnt_nxt   = '0;
                state_nxt = S_UP;
            end
        end
        if (!en) begin
            cnt_nxt   = '0;
            state_nxt = S_UP;
        end
    end

    // Counter/direction state register
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            cnt   <= '0;
            state <= S_UP;
        end else begin
            cnt   <= cnt_nxt;
            state <= state_nxt;
        end
    end

    // Shadow settings move to active at a boundary, or straight away while disabled
    assign commit = pending && (bnd || !en);

    // Shadow capture, commit and pending flag; a load coinciding with a commit stays pending
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            p_sh     <= '0;
            duty_sh  <= '0;
            c_sh     <= MODE_EDGE;
            p_act    <= '0;
            duty_act <= '0;
            c_act    <= MODE_EDGE;
            pending  <= 1'b0;
        end else begin
            if (load) begin
                p_sh    <= period;
                duty_sh <= duty;
                c_sh    <= center;
            end
            if (commit) begin
                p_act    <= p_sh;
                duty_act <= duty_sh;
                c_act    <= c_sh;
            end
            pending <= load | (pending & ~commit);
        end
    end

    // Period boundary pulse, one cycle after the boundary tick
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            period_tick <= 1'b0;
        end else begin
            period_tick <= bnd;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pwm_ch_cmp #(
            .CW(CW)
        ) u_cmp (
            .sclk    (sclk),
            .rstn    (rstn),
            .en      (en),
            .cnt     (cnt),
            .duty_act(duty_act[i*CW +: CW]),
            .polarity(polarity[i]),
            .pwm_out (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - self-checking bench for pwm_multi against a phase-based reference model
module tb_pwm_multi;

    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int PSW = 8;

    logic              sclk = 1'b0;
    logic              rstn = 1'b0;
    logic              en = 1'b0;
    logic [PSW-1:0]    prescale = '0;
    logic [CW-1:0]     period = '0;
    logic [NCH*CW-1:0] duty = '0;
    logic              center = 1'b0;
    logic [NCH-1:0]    polarity = '0;
    logic              load = 1'b0;
    logic              pending;
    logic              period_tick;
    logic [NCH-1:0]    pwm_out;

    pwm_multi #(.NCH(NCH), .CW(CW), .PSW(PSW)) dut (
        .sclk       (sclk),
        .rstn       (rstn),
        .en         (en),
        .prescale   (prescale),
        .period     (period),
        .duty       (duty),
        .center     (center),
        .polarity   (polarity),
        .load       (load),
        .pending    (pending),
        .period_tick(period_tick),
        .pwm_out    (pwm_out)
    );

    always #5 sclk = ~sclk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: position within the period (m_k) and prescaler phase (m_pc)
    int unsigned       m_pc, m_k;
    logic [CW-1:0]     a_p, s_p;
    logic [NCH*CW-1:0] a_d, s_d;
    logic              a_c, s_c;
    logic              m_pend;
    logic [NCH-1:0]    e_out;
    logic              e_tick;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_k = 0;
        a_p = '0; s_p = '0; a_d = '0; s_d = '0; a_c = 1'b0; s_c = 1'b0;
        m_pend = 1'b0; e_out = '0; e_tick = 1'b0;
    endtask

    // One clock: predict from the pre-edge state, clock, then compare
    task automatic step();
        int unsigned L, c;
        logic tk, bnd, cm, ld;
        logic [NCH-1:0] n_out;
        logic [CW-1:0] in_p;
        logic [NCH*CW-1:0] in_d;
        logic in_c;
        L = a_c ? ((a_p == 0) ? 1 : 2 * int'(a_p)) : int'(a_p) + 1;
        c = (a_c && m_k > a_p) ? 2 * int'(a_p) - m_k : m_k;
        tk = en && (m_pc >= prescale);
        bnd = tk && (m_k == L - 1);
        for (int i = 0; i < NCH; i++)
            n_out[i] = en ? ((c < a_d[i*CW +: CW]) ^ polarity[i]) : polarity[i];
        cm = (bnd || !en) && m_pend;
        ld = load; in_p = period; in_d = duty; in_c = center;
        @(posedge sclk);
        #1;
        e_out = n_out;
        e_tick = bnd;
        m_pc = (!en || tk) ? 0 : m_pc + 1;
        m_k = (!en || bnd) ? 0 : (tk ? m_k + 1 : m_k);
        if (cm) begin a_p = s_p; a_d = s_d; a_c = s_c; end
        if (ld) begin s_p = in_p; s_d = in_d; s_c = in_c; end
        m_pend = ld | (m_pend & ~cm);
        chk("pwm_out", 64'(pwm_out), 64'(e_out));
        chk("period_tick", 64'(period_tick), 64'(e_tick));
        chk("pending", 64'(pending), 64'(m_pend));
    endtask

    task automatic setup(input int ps, input int p, input int d0, input logic ctr, input logic pol0);
        en = 1'b0;
        prescale = PSW'(ps);
        period = CW'(p);
        center = ctr;
        for (int i = 1; i < NCH; i++) duty[i*CW +: CW] = CW'($urandom_range(p + 1, 0));
        duty[CW-1:0] = CW'(d0);
        polarity = NCH'($urandom) & ~NCH'(1);
        polarity[0] = pol0;
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        en = 1'b1;
    endtask

    task automatic count(input int n, output int highs, output int ticks);
        highs = 0; ticks = 0;
        for (int i = 0; i < n; i++) begin
            step();
            highs += int'(pwm_out[0]);
            ticks += int'(period_tick);
        end
    endtask

    task automatic wait_k(input int unsigned target);
        int n = 0;
        while (m_k != target && n < 200) begin step(); n++; end
        chk("wait_k_timeout", 64'(m_k == target), 64'(1));
    endtask

    typedef struct {
        int   ps;
        int   p;
        int   d0;
        logic ctr;
        logic pol0;
        int   cycles;
        int   exp_high;
        int   exp_ticks;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int h, t;
        tbl[0] = '{0, 9,  3, 1'b0, 1'b0, 30,  9, 3};
        tbl[1] = '{0, 4,  2, 1'b1, 1'b0, 24,  9, 3};
        tbl[2] = '{0, 9,  0, 1'b0, 1'b0, 30,  0, 3};
        tbl[3] = '{0, 9, 10, 1'b0, 1'b0, 30, 30, 3};
        tbl[4] = '{0, 9,  3, 1'b0, 1'b1, 30, 21, 3};
        tbl[5] = '{2, 9,  3, 1'b0, 1'b0, 90, 27, 3};
        tbl[6] = '{0, 0,  1, 1'b1, 1'b0,  3,  3, 3};
        tbl[7] = '{1, 1,  1, 1'b1, 1'b0, 12,  6, 3};

        model_reset();
        repeat (2) @(posedge sclk);
        #1;
        chk("reset_pwm_out", 64'(pwm_out), 64'(0));
        chk("reset_pending", 64'(pending), 64'(0));
        chk("reset_tick", 64'(period_tick), 64'(0));
        rstn = 1'b1;

        for (int r = 0; r < 8; r++) begin
            setup(tbl[r].ps, tbl[r].p, tbl[r].d0, tbl[r].ctr, tbl[r].pol0);
            count(tbl[r].cycles, h, t);
            chk($sformatf("row%0d_highs", r), 64'(h), 64'(tbl[r].exp_high));
            chk($sformatf("row%0d_ticks", r), 64'(t), 64'(tbl[r].exp_ticks));
        end

        // Mid-period load keeps the current period, commits at the boundary
        setup(0, 9, 3, 1'b0, 1'b0);
        wait_k(5);
        duty[CW-1:0] = CW'(2);
        load = 1'b1;
        step();
        load = 1'b0;
        chk("midload_pending", 64'(pending), 64'(1));
        wait_k(9);
        step();
        chk("midload_tick", 64'(period_tick), 64'(1));
        chk("midload_committed", 64'(pending), 64'(0));
        count(10, h, t);
        chk("midload_highs", 64'(h), 64'(2));

        // Load on the boundary cycle: old shadow commits, new one stays pending
        wait_k(4);
        duty[CW-1:0] = CW'(5);
        load = 1'b1;
        step();
        load = 1'b0;
        wait_k(9);
        duty[CW-1:0] = CW'(6);
        load = 1'b1;
        step();
        load = 1'b0;
        chk("coinc_tick", 64'(period_tick), 64'(1));
        chk("coinc_pending", 64'(pending), 64'(1));
        count(10, h, t);
        chk("coinc_highs_old", 64'(h), 64'(5));
        chk("coinc_pending_clr", 64'(pending), 64'(0));
        count(10, h, t);
        chk("coinc_highs_new", 64'(h), 64'(6));

        // Disable drives the inactive level and restarts from cnt=0
        polarity = 4'b1010;
        en = 1'b0;
        step();
        chk("disable_out", 64'(pwm_out), 64'(4'b1010));
        en = 1'b1;
        polarity = 4'b0000;
        count(10, h, t);
        chk("reenable_highs", 64'(h), 64'(6));

        // Asynchronous reset mid-period
        wait_k(3);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_out", 64'(pwm_out), 64'(0));
        chk("async_rst_pending", 64'(pending), 64'(0));
        model_reset();
        @(posedge sclk);
        #1;
        rstn = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            load = 1'b0;
            if ($urandom_range(15, 0) == 0) begin
                int p;
                p = $urandom_range(12, 0);
                period = CW'(p);
                center = 1'($urandom);
                for (int i = 0; i < NCH; i++) duty[i*CW +: CW] = CW'($urandom_range(p + 2, 0));
                load = 1'b1;
            end
            if ($urandom_range(31, 0) == 0) polarity = NCH'($urandom);
            if ($urandom_range(63, 0) == 0) en = ~en;
            if (!en && $urandom_range(3, 0) == 0) prescale = PSW'($urandom_range(3, 0));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
